// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-channel TDM receiver.
// It tracks frame alignment from in_sof, stages samples, and presents each complete frame on four parallel outputs.
module tdm_demux4 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  ch;
    logic [1:0]  ch_next;
    logic [DATA_W-1:0] sh0;
    logic [DATA_W-1:0] sh1;
    logic [DATA_W-1:0] sh2;

    logic load_sh0;
    logic load_sh1;
    logic load_sh2;
    logic frame_done;
    logic err_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            ch    <= 2'd0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
        end
    end

    // Every accepted SOF restarts the slot count at channel 1, whether it locks, realigns, or resyncs.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_sof) begin
                        state_next = LOCKED;
                        ch_next    = 2'd1;
                    end
                end
                LOCKED: begin
                    if (in_sof) begin
                        ch_next = 2'd1;
                    end else if (ch == 2'd0) begin
                        state_next = HUNT;
                        ch_next    = 2'd0;
                    end else begin
                        ch_next = ch + 2'd1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    ch_next    = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        load_sh0   = 1'b0;
        load_sh1   = 1'b0;
        load_sh2   = 1'b0;
        frame_done = 1'b0;
        err_now    = 1'b0;
        if (in_valid) begin
            load_sh0 = in_sof;
            if (state == LOCKED) begin
                err_now    = in_sof ? (ch != 2'd0) : (ch == 2'd0);
                load_sh1   = !in_sof && (ch == 2'd1);
                load_sh2   = !in_sof && (ch == 2'd2);
                frame_done = !in_sof && (ch == 2'd3);
            end
        end
    end

    // Outputs only move on a completed frame, so an abandoned partial frame never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
            frame_cnt   <= 8'd0;
            err_cnt     <= 8'd0;
        end else begin
            if (load_sh0) sh0 <= in_data;
            if (load_sh1) sh1 <= in_data;
            if (load_sh2) sh2 <= in_data;
            if (frame_done) begin
                out0      <= sh0;
                out1      <= sh1;
                out2      <= sh2;
                out3      <= in_data;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (err_now && (err_cnt != 8'd255)) err_cnt <= err_cnt + 8'd1;
            frame_valid <= frame_done;
            sync_err    <= err_now;
            locked      <= (state_next == LOCKED);
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4: a table of hand-computed vectors, directed corner sequences,
// and random traffic checked against a queue-based frame model.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sof;
    logic [7:0] out0, out1, out2, out3;
    logic       frame_valid, locked, sync_err;
    logic [7:0] frame_cnt, err_cnt;

    int nVectors = 0;
    int nMiscompares = 0;

    always #5 clk = ~clk;

    tdm_demux4 #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] d;
        logic [7:0] o0, o1, o2, o3;
        logic       fv, lk, se;
        logic [7:0] fc, ec;
    } vec_t;

    vec_t tbl[$];

    // Reference model: samples of the frame being collected sit in a queue; the frame is complete at four entries.
    logic [7:0] mQ[$];
    bit         mLocked;
    logic [7:0] mOut[4];
    logic       mFv, mSe;
    logic [7:0] mFc, mEc;

    task automatic modelReset();
        mQ.delete();
        mLocked = 0;
        for (int i = 0; i < 4; i++) mOut[i] = 8'h00;
        mFv = 0; mSe = 0; mFc = 8'd0; mEc = 8'd0;
    endtask

    task automatic modelError();
        mSe = 1;
        if (mEc != 8'd255) mEc = mEc + 8'd1;
    endtask

    task automatic modelStep(input logic v, input logic sof, input logic [7:0] d);
        mFv = 0;
        mSe = 0;
        if (!v) return;
        if (sof) begin
            if (mLocked && mQ.size() != 0) modelError();
            mQ.delete();
            mQ.push_back(d);
            mLocked = 1;
        end else if (mLocked) begin
            if (mQ.size() == 0) begin
                modelError();
                mLocked = 0;
            end else begin
                mQ.push_back(d);
                if (mQ.size() == 4) begin
                    for (int i = 0; i < 4; i++) mOut[i] = mQ[i];
                    mFv = 1;
                    mFc = mFc + 8'd1;
                    mQ.delete();
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input string field, input int act, input int exp);
        if (act != exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic efv, input logic elk, input logic ese,
                               input logic [7:0] efc, input logic [7:0] eec);
        nVectors++;
        cmp(tag, "out0", int'(out0), int'(e0));
        cmp(tag, "out1", int'(out1), int'(e1));
        cmp(tag, "out2", int'(out2), int'(e2));
        cmp(tag, "out3", int'(out3), int'(e3));
        cmp(tag, "frame_valid", int'(frame_valid), int'(efv));
        cmp(tag, "locked", int'(locked), int'(elk));
        cmp(tag, "sync_err", int'(sync_err), int'(ese));
        cmp(tag, "frame_cnt", int'(frame_cnt), int'(efc));
        cmp(tag, "err_cnt", int'(err_cnt), int'(eec));
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, mOut[0], mOut[1], mOut[2], mOut[3], mFv, mLocked, mSe, mFc, mEc);
    endtask

    // Drive on the falling edge, let the rising edge accept, then sample 1 time unit later.
    task automatic applyStimulus(input logic v, input logic sof, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        modelStep(v, sof, d);
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic v, input logic sof, input logic [7:0] d);
        applyStimulus(v, sof, d);
        checkModel(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkModel("reset");
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        stepCheck(tag, 1'b1, 1'b1, a);
        stepCheck(tag, 1'b1, 1'b0, b);
        stepCheck(tag, 1'b1, 1'b0, c);
        stepCheck(tag, 1'b1, 1'b0, d);
    endtask

    task automatic addVec(input logic v, input logic sof, input logic [7:0] d,
                          input logic [7:0] o0, input logic [7:0] o1,
                          input logic [7:0] o2, input logic [7:0] o3,
                          input logic fv, input logic lk, input logic se,
                          input logic [7:0] fc, input logic [7:0] ec);
        vec_t r;
        r.v = v; r.sof = sof; r.d = d;
        r.o0 = o0; r.o1 = o1; r.o2 = o2; r.o3 = o3;
        r.fv = fv; r.lk = lk; r.se = se; r.fc = fc; r.ec = ec;
        tbl.push_back(r);
    endtask

    initial begin
        logic [7:0] gapData[4];
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;

        addVec(1, 1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'd0, 8'd0);
        addVec(1, 0, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'd0, 8'd0);
        addVec(1, 0, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'd0, 8'd0);
        addVec(1, 0, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1, 0, 8'd1, 8'd0);
        addVec(0, 0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 8'd1, 8'd0);
        addVec(1, 0, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 1, 8'd1, 8'd1);
        addVec(1, 0, 8'h66, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 8'd1, 8'd1);
        addVec(1, 1, 8'hA0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 8'd1, 8'd1);
        addVec(1, 0, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 8'd1, 8'd1);
        addVec(1, 1, 8'hB0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 1, 8'd1, 8'd2);
        addVec(1, 0, 8'hB1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 8'd1, 8'd2);
        addVec(0, 0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 8'd1, 8'd2);
        addVec(1, 0, 8'hB2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 8'd1, 8'd2);
        addVec(1, 0, 8'hB3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 1, 1, 0, 8'd2, 8'd2);
        addVec(0, 1, 8'hEE, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 0, 1, 0, 8'd2, 8'd2);

        doReset();

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, tbl[i].sof, tbl[i].d);
            checkOutput($sformatf("table[%0d]", i), tbl[i].o0, tbl[i].o1, tbl[i].o2, tbl[i].o3,
                        tbl[i].fv, tbl[i].lk, tbl[i].se, tbl[i].fc, tbl[i].ec);
        end

        // Same frame with 1..3 idle cycles between samples.
        doReset();
        gapData[0] = 8'h11; gapData[1] = 8'h22; gapData[2] = 8'h33; gapData[3] = 8'h44;
        for (int s = 0; s < 4; s++) begin
            stepCheck("gap_sample", 1'b1, (s == 0), gapData[s]);
            if (s != 3) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                    stepCheck("gap_idle", 1'b0, 1'b0, 8'($urandom));
            end
        end
        stepCheck("gap_after", 1'b0, 1'b0, 8'h00);

        // Back-to-back frames with no idle cycles.
        for (int f = 0; f < 3; f++)
            sendFrame("b2b", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Loss of lock, then stray samples in HUNT, then relock.
        stepCheck("unlock", 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 3; i++) stepCheck("hunt_drop", 1'b1, 1'b0, 8'($urandom));
        sendFrame("relock", 8'hC0, 8'hC1, 8'hC2, 8'hC3);

        // Reset between the 2nd and 3rd sample of a frame.
        stepCheck("pre_rst", 1'b1, 1'b1, 8'hD0);
        stepCheck("pre_rst", 1'b1, 1'b0, 8'hD1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCheck("post_rst_drop", 1'b1, 1'b0, 8'hD2);
        sendFrame("post_rst", 8'hE0, 8'hE1, 8'hE2, 8'hE3);
        checkOutput("post_rst_outs", 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0);

        // frame_cnt wrap after 256 frames.
        doReset();
        for (int f = 0; f < 256; f++)
            sendFrame("wrap", 8'(f), 8'(f + 1), 8'(f + 2), 8'(f + 3));
        checkOutput("wrap_end", 8'd255, 8'd0, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);

        // err_cnt saturation with 300 early SOFs.
        doReset();
        stepCheck("sat_lock", 1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 300; i++) stepCheck("sat", 1'b1, 1'b1, 8'($urandom));
        checkOutput("sat_end", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0, 8'd255);

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic v, s;
            v = ($urandom_range(0, 9) < 8);
            s = ($urandom_range(0, 3) == 0);
            stepCheck("random", v, s, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer that inverts the 4:1 selection path: it takes a single time-multiplexed sample stream, tracks the channel slot with a frame-synchronising state machine, and reassembles each 4-sample frame into four parallel channel outputs. Samples are staged in shadow registers, and the four outputs update atomically when a frame completes. The block sits at the receiving end of the team's 4-channel TDM link, after the serial sample source and ahead of per-channel consumers.

## Interface
Parameters:
- DATA_W, 8, sample width in bits

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample present on in_data this cycle
- in_data  input  DATA_W  time-multiplexed sample
- in_sof  input  1  start of frame; qualifies in_data as channel 0; ignored when in_valid=0
- out0, out1, out2, out3  output  DATA_W  channel 0..3 samples of last complete frame
- frame_valid  output  1  one-cycle pulse when out0..out3 update
- locked  output  1  1 while the state machine is in LOCKED
- sync_err  output  1  one-cycle pulse on a framing violation
- frame_cnt  output  8  completed frames, wraps 255->0
- err_cnt  output  8  framing violations, saturates at 255

## Operation
- Internal state: fsm {HUNT, LOCKED}, 2-bit slot counter ch, shadow registers sh0..sh2 (DATA_W each).
- An accepted sample is one with in_valid=1 at a rising clk edge. Cycles with in_valid=0 do not change state; ch holds, so gaps are allowed anywhere in a frame.
- HUNT:
  - in_valid & in_sof: sh0<=in_data, ch<=1, go to LOCKED.
  - in_valid & !in_sof: sample dropped, no error.
- LOCKED, ch=0:
  - in_valid & in_sof: sh0<=in_data, ch<=1.
  - in_valid & !in_sof: sync_err pulse, err_cnt++, sample dropped, go to HUNT, ch<=0.
- LOCKED, ch=1 or 2:
  - in_valid & !in_sof: sh[ch]<=in_data, ch<=ch+1.
- LOCKED, ch=3:
  - in_valid & !in_sof: out0..out2<=sh0..sh2, out3<=in_data, frame_valid pulse, frame_cnt++, ch<=0.
- LOCKED, ch≠0, in_valid & in_sof (early SOF): sync_err pulse, err_cnt++, the partial frame is discarded (outputs untouched), sh0<=in_data, ch<=1, stay in LOCKED.
- out0..out3 hold their value until the next completed frame. A partial frame never reaches the outputs.
- frame_cnt wraps modulo 256. err_cnt stops at 255.
- locked = (fsm==LOCKED), registered.

## Timing
- Reset (asynchronous assert, synchronous release): fsm=HUNT, ch=0, sh0..sh2=0, out0..out3=0, frame_valid=0, sync_err=0, locked=0, frame_cnt=0, err_cnt=0.
- A reset mid-frame discards the partial frame immediately. The first accepted sample after release is treated as in HUNT.
- All outputs are registered.
- The SOF accepted at edge k makes locked=1 after edge k.
- With the channel-3 sample accepted at edge k, the following are visible after edge k:
  - new out0..out3
  - frame_valid=1 for exactly one cycle
  - frame_cnt incremented
- Minimum frame period is 4 cycles. Back-to-back frames give a frame_valid pulse every 4th cycle with no dead cycles.
- sync_err and the err_cnt increment appear after the edge that accepts the offending sample.
- frame_valid and sync_err are never asserted in the same cycle.
- Throughput is 1 sample/cycle. There is no backpressure; the source is never stalled.

## Test plan
- Reset, then stream SOF:0x11, 0x22, 0x33, 0x44 on consecutive cycles -> locked=1 after the first edge; after the 4th edge out0..3=0x11/0x22/0x33/0x44, frame_valid high for 1 cycle, frame_cnt=1.
- Same frame with in_valid=0 gaps of 1–3 cycles between samples -> identical outputs; frame_valid occurs only after the 0x44 sample.
- After a good frame, send SOF:0xA0, 0xA1, then SOF:0xB0, 0xB1, 0xB2, 0xB3 -> sync_err pulse at the second SOF, err_cnt=1, outputs stay at the previous frame until they become 0xB0/0xB1/0xB2/0xB3, frame_cnt incremented by 1.
- In LOCKED with ch=0, send non-SOF 0x55 -> sync_err, locked=0, 0x55 dropped; the following non-SOF samples are ignored with no further errors until the next SOF relocks.
- Run 256 good frames -> frame_cnt wraps to 0. Force 300 early SOFs -> err_cnt holds at 255.
- Assert rst_n=0 between the 2nd and 3rd sample of a frame -> all outputs return to 0 immediately; after release, a non-SOF sample is dropped and the next SOF frame decodes correctly.
